spmv_mem_responder: RTL and testbench

SPMV_MEM_RESPONDER -- requirements
Module: spmv_mem_responder

---
 rtl/spmv_mem_if.sv | 22 ++
 rtl/spmv_mem_responder.sv | 150 +++++++++++++++
 tb/tb_spmv_mem_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/spmv_mem_if.sv
// Request/response bus between an SpMV requester and its memory responder.
interface spmv_mem_if;
    logic        req_mem_ld;
    logic        req_mem_st;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic        req_mem_stall;
    logic        rsp_mem_push;
    logic [2:0]  rsp_mem_tag;
    logic [63:0] rsp_mem_q;
    logic        rsp_mem_stall;

    modport master (
        output req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, rsp_mem_stall,
        input  req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
    );

    modport slave (
        input  req_mem_ld, req_mem_st, req_mem_addr, req_mem_d_or_tag, rsp_mem_stall,
        output req_mem_stall, rsp_mem_push, rsp_mem_tag, rsp_mem_q
    );
endinterface

// File: rtl/spmv_mem_responder.sv
// Fixed-latency 64-bit memory responder with in-order response FIFO and credit-style stall.
// Define SPMV_MEM_RSP_ERR_EN to enable the sticky protocol-error flag.
module spmv_mem_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int LATENCY      = 4,
    parameter int RSP_DEPTH    = 16,
    parameter int STALL_MARGIN = 6
) (
    input  logic       clk,
    input  logic       rst,
    spmv_mem_if.slave  bus,
    output logic       err
);
    localparam int PIPE  = LATENCY - 2;
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int OCC_W = $clog2(RSP_DEPTH + 1);
    localparam int WORDS = 1 << ADDR_BITS;

    logic [ADDR_BITS-1:0] word_idx;
    logic [2:0]           ld_tag;
    logic [OCC_W-1:0]     occ_reg, occ_next;
    logic                 occ_full, st_ok, ld_ok, pop, fifo_empty;
    logic                 stall_reg, push_reg;
    logic [2:0]           tag_reg;
    logic [63:0]          q_reg;
    logic [PTR_W:0]       wr_ptr_reg, rd_ptr_reg;
    logic                 unused_addr;

    assign word_idx    = bus.req_mem_addr[ADDR_BITS+2:3];
    assign ld_tag      = bus.req_mem_d_or_tag[2:0];
    assign unused_addr = ^{bus.req_mem_addr[47:ADDR_BITS+3], bus.req_mem_addr[2:0]};

    // Occupancy counts in-flight loads too, so a load accepted below RSP_DEPTH always has a FIFO slot.
    assign occ_full = (occ_reg == OCC_W'(RSP_DEPTH));
    assign st_ok    = bus.req_mem_st && !rst;
    assign ld_ok    = bus.req_mem_ld && !bus.req_mem_st && !occ_full && !rst;

    logic [63:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (st_ok)
            mem[word_idx] <= bus.req_mem_d_or_tag;
    end

    logic        fifo_wr;
    logic [2:0]  fifo_wr_tag;
    logic [63:0] fifo_wr_data;

    generate
        if (PIPE == 0) begin : g_direct
            assign fifo_wr      = ld_ok;
            assign fifo_wr_tag  = ld_tag;
            assign fifo_wr_data = mem[word_idx];
        end else begin : g_pipe
            logic        vld_reg  [PIPE];
            logic [2:0]  ptag_reg [PIPE];
            logic [63:0] data_reg [PIPE];

            // Stage 0 is the registered memory read; later stages only delay.
            always_ff @(posedge clk) begin
                data_reg[0] <= mem[word_idx];
                ptag_reg[0] <= ld_tag;
                for (int i = 1; i < PIPE; i++) begin
                    data_reg[i] <= data_reg[i-1];
                    ptag_reg[i] <= ptag_reg[i-1];
                end
                if (rst) begin
                    for (int i = 0; i < PIPE; i++)
                        vld_reg[i] <= 1'b0;
                end else begin
                    vld_reg[0] <= ld_ok;
                    for (int i = 1; i < PIPE; i++)
                        vld_reg[i] <= vld_reg[i-1];
                end
            end

            assign fifo_wr      = vld_reg[PIPE-1];
            assign fifo_wr_tag  = ptag_reg[PIPE-1];
            assign fifo_wr_data = data_reg[PIPE-1];
        end
    endgenerate

    logic [63:0] fifo_data [RSP_DEPTH];
    logic [2:0]  fifo_tag  [RSP_DEPTH];

    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign pop        = !fifo_empty && !bus.rsp_mem_stall;

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_data[wr_ptr_reg[PTR_W-1:0]] <= fifo_wr_data;
            fifo_tag[wr_ptr_reg[PTR_W-1:0]]  <= fifo_wr_tag;
        end
    end

    always_comb begin
        occ_next = occ_reg;
        case ({ld_ok, pop})
            2'b10:   occ_next = occ_reg + OCC_W'(1);
            2'b01:   occ_next = occ_reg - OCC_W'(1);
            default: occ_next = occ_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            stall_reg  <= 1'b0;
            push_reg   <= 1'b0;
            tag_reg    <= '0;
            q_reg      <= '0;
        end else begin
            if (fifo_wr)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                q_reg      <= fifo_data[rd_ptr_reg[PTR_W-1:0]];
                tag_reg    <= fifo_tag[rd_ptr_reg[PTR_W-1:0]];
            end
            push_reg  <= pop;
            occ_reg   <= occ_next;
            stall_reg <= (occ_next >= OCC_W'(RSP_DEPTH - STALL_MARGIN));
        end
    end

`ifdef SPMV_MEM_RSP_ERR_EN
    logic err_reg;
    logic ld_drop;

    assign ld_drop = bus.req_mem_ld && (bus.req_mem_st || occ_full) && !rst;

    always_ff @(posedge clk) begin
        if (rst)
            err_reg <= 1'b0;
        else if (ld_drop)
            err_reg <= 1'b1;
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign bus.req_mem_stall = stall_reg;
    assign bus.rsp_mem_push  = push_reg;
    assign bus.rsp_mem_tag   = tag_reg;
    assign bus.rsp_mem_q     = q_reg;
endmodule

// File: tb/tb_spmv_mem_responder.sv
// Self-checking bench for spmv_mem_responder: vector table plus scoreboard of expected responses.
module tb_spmv_mem_responder;
    localparam int LATENCY = 4;
`ifdef SPMV_MEM_RSP_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    spmv_mem_if bus ();

    spmv_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  tag;
        logic [63:0] data;
    } rsp_t;

    typedef struct {
        logic [47:0] st_addr;
        logic [47:0] ld_addr;
        logic [63:0] data;
    } vec_t;

    rsp_t        sb [$];
    int          push_cycles [$];
    logic [63:0] model_mem [1024];
    vec_t        vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [47:0] a);
        return int'(a[12:3]);
    endfunction

    task automatic req(input logic ld, input logic st, input logic [47:0] a, input logic [63:0] d);
        bus.req_mem_ld       = ld;
        bus.req_mem_st       = st;
        bus.req_mem_addr     = a;
        bus.req_mem_d_or_tag = d;
        @(posedge clk);
        #1;
        bus.req_mem_ld = 1'b0;
        bus.req_mem_st = 1'b0;
    endtask

    task automatic store(input logic [47:0] a, input logic [63:0] d);
        req(1'b0, 1'b1, a, d);
        model_mem[widx(a)] = d;
    endtask

    task automatic load(input logic [47:0] a, input logic [2:0] t);
        sb.push_back('{tag: t, data: model_mem[widx(a)]});
        req(1'b1, 1'b0, a, {61'd0, t});
    endtask

    task automatic drain(input string name, input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_mem_push) begin
            push_cycles.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_push: got tag %0d q %h expected no response",
                         bus.rsp_mem_tag, bus.rsp_mem_q);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                $display("rsp cyc=%0d tag=%0d q=%h", cyc, bus.rsp_mem_tag, bus.rsp_mem_q);
                check("rsp_tag", 64'(bus.rsp_mem_tag), 64'(e.tag));
                check("rsp_q", bus.rsp_mem_q, e.data);
            end
        end
    end

    initial begin
        int first_edge;
        int n;

        vecs[0] = '{48'h0000_0000_0000, 48'h0000_0000_0000, 64'hDEAD_BEEF_0000_0001};
        vecs[1] = '{48'h0000_0000_0008, 48'h0000_0000_000C, 64'h0123_4567_89AB_CDEF};
        vecs[2] = '{48'h0000_0000_01F8, 48'h0000_0000_01F8, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{48'h0000_0000_1FF8, 48'hFFFF_FFFF_FFF8, 64'hA5A5_5A5A_A5A5_5A5A};
        vecs[4] = '{48'h0000_0000_0100, 48'h0000_0000_2100, 64'h0000_0000_0000_0000};
        vecs[5] = '{48'h0000_0000_0010, 48'h8000_0000_0010, 64'h8000_0000_0000_0001};
        vecs[6] = '{48'h0000_0000_0A00, 48'h0000_0000_0A00, 64'h1357_9BDF_2468_ACE0};
        vecs[7] = '{48'h0000_0000_0048, 48'h0000_0000_0048, 64'hCAFE_F00D_1234_5678};

        bus.req_mem_ld       = 1'b0;
        bus.req_mem_st       = 1'b0;
        bus.req_mem_addr     = '0;
        bus.req_mem_d_or_tag = '0;
        bus.rsp_mem_stall    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_stall", 64'(bus.req_mem_stall), 64'd0);
        check("reset_push", 64'(bus.rsp_mem_push), 64'd0);
        check("reset_err", 64'(err), 64'd0);
        check("reset_tag", 64'(bus.rsp_mem_tag), 64'd0);
        check("reset_q", bus.rsp_mem_q, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Store then load next cycle: latency, data, tag, then hold while idle.
        push_cycles.delete();
        store(48'h40, 64'h1122_3344_5566_7788);
        load(48'h40, 3'd5);
        first_edge = cyc;
        drain("st_ld_drain", 20);
        check("st_ld_latency", 64'(push_cycles.size() > 0 ? push_cycles[0] - first_edge : -1),
              64'(LATENCY - 1));
        @(negedge clk);
        check("hold_push", 64'(bus.rsp_mem_push), 64'd0);
        check("hold_q", bus.rsp_mem_q, 64'h1122_3344_5566_7788);
        check("hold_tag", 64'(bus.rsp_mem_tag), 64'd5);

        // Load then store to the same word: the load returns the old value.
        load(48'h40, 3'd2);
        store(48'h40, 64'h9999_0000_9999_0000);
        load(48'h40, 3'd6);
        drain("ld_st_drain", 20);

        // Table: stores, then eight back-to-back (partly aliased) loads tags 0..7.
        for (int i = 0; i < 8; i++)
            store(vecs[i].st_addr, vecs[i].data);
        push_cycles.delete();
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{tag: 3'(i), data: vecs[i].data});
            req(1'b1, 1'b0, vecs[i].ld_addr, 64'(i));
            if (i == 0)
                first_edge = cyc;
        end
        drain("b2b_drain", 30);
        check("b2b_count", 64'(push_cycles.size()), 64'd8);
        for (int i = 0; i < 8 && i < push_cycles.size(); i++)
            check("b2b_cycle", 64'(push_cycles[i] - first_edge), 64'(LATENCY - 1 + i));

        // Response stall: fill until req_mem_stall, three more, then to full, then one dropped.
        idle(2);
        bus.rsp_mem_stall = 1'b1;
        n = 0;
        while (!bus.req_mem_stall && n < 20) begin
            load(vecs[n % 8].st_addr, 3'(n));
            n++;
        end
        check("stall_threshold", 64'(n), 64'd10);
        for (int i = 0; i < 3; i++)
            load(vecs[(n + i) % 8].st_addr, 3'(n + i));
        check("stall_no_err", 64'(err), 64'd0);
        for (int i = 0; i < 3; i++)
            load(vecs[(n + 3 + i) % 8].st_addr, 3'(n + 3 + i));
        req(1'b1, 1'b0, vecs[0].st_addr, 64'd7);
        idle(2);
        check("full_drop_err", 64'(err), 64'(ERR_EN));
        check("full_no_push", 64'(bus.rsp_mem_push), 64'd0);
        check("full_pending", 64'(sb.size()), 64'd16);
        bus.rsp_mem_stall = 1'b0;
        drain("full_drain", 60);
        idle(8);

        // Reset clears err and status.
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_err", 64'(err), 64'd0);
        check("rst2_req_stall", 64'(bus.req_mem_stall), 64'd0);

        // Load and store together: store only, load dropped.
        req(1'b1, 1'b1, 48'h8, 64'hAB);
        model_mem[1] = 64'hAB;
        idle(LATENCY + 3);
        check("ldst_err", 64'(err), 64'(ERR_EN));
        load(48'h8, 3'd3);
        drain("ldst_readback", 20);

        // Reset with three loads in flight: no responses, memory preserved.
        req(1'b1, 1'b0, vecs[6].st_addr, 64'd1);
        req(1'b1, 1'b0, vecs[7].st_addr, 64'd2);
        req(1'b1, 1'b0, vecs[3].st_addr, 64'd3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(LATENCY + 6);
        check("rst3_req_stall", 64'(bus.req_mem_stall), 64'd0);
        check("rst3_push", 64'(bus.rsp_mem_push), 64'd0);
        load(vecs[6].st_addr, 3'd4);
        load(48'h40, 3'd1);
        drain("rst3_readback", 20);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
